shift_load_reg: RTL and testbench

//   Parametrised parallel-load register with a sequenced multi-bit shifter:

---
 rtl/shift_load_reg.sv | 127 ++++++++++++
 tb/tb_shift_load_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_load_reg.sv
// Parallel-load holding register with a sequenced one-bit-per-clock shifter
// (LSR/LSL/ASR/ROR) and a Start/Busy/Done handshake.
//
// state   | meaning
// S_IDLE  | waiting for Load or Start
// S_SHIFT | one shift per edge, rem_q shifts still to go
// S_DONE  | one-cycle Done; new requests accepted here as in S_IDLE
module shift_load_reg #(
  parameter int               WIDTH     = 17,
  parameter int               MAX_SHIFT = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CW-1:0]    Count,
  input  logic             Serial_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Serial_Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0]    MODE_LSR = 2'b00;
  localparam logic [1:0]    MODE_LSL = 2'b01;
  localparam logic [1:0]    MODE_ASR = 2'b10;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_SHIFT);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    n_req;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    n_req   = (Count > MAX_CNT) ? MAX_CNT : Count;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Load) begin
          data_d = D;
        end else if (Start) begin
          mode_d = Mode;
          rem_d  = n_req;
          state_d = (n_req == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        case (mode_q)
          MODE_LSR: begin
            data_d = {Serial_In, data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
          MODE_LSL: begin
            data_d = {data_q[WIDTH-2:0], Serial_In};
            sout_d = data_q[WIDTH-1];
          end
          MODE_ASR: begin
            data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
          default: begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
        endcase
        rem_d = rem_q - ONE_CNT;
        if (rem_q == ONE_CNT) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are flops decoded from the next state.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      data_q  <= RESET_VAL;
      sout_q  <= 1'b0;
      mode_q  <= MODE_LSR;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Data_Out   = data_q;
  assign Serial_Out = sout_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_shift_load_reg.sv
// Bench for shift_load_reg: directed vector table, hand-written corner
// sequences, and random sequences against a word-level reference model.
module tb_shift_load_reg;

  localparam int W = 17;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Load;
  logic [W-1:0] D;
  logic         Start;
  logic [1:0]   Mode;
  logic [4:0]   Count;
  logic         Serial_In;
  logic [W-1:0] Data_Out;
  logic         Serial_Out;
  logic         Busy;
  logic         Done;

  shift_load_reg dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Start(Start),
    .Mode(Mode), .Count(Count), .Serial_In(Serial_In),
    .Data_Out(Data_Out), .Serial_Out(Serial_Out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] m_data;
  logic         m_sout;
  int           last_busy;

  typedef struct {
    bit           load;
    logic [W-1:0] d;
    logic [1:0]   mode;
    logic [4:0]   cnt;
    bit           si;
    logic [W-1:0] exp_d;
    bit           exp_so;
    int           exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Word-level reference: apply n single-position shifts using the fill bits seen.
  task automatic model_shift(input logic [1:0] m, input int n, input bit sis[$]);
    logic [W-1:0] d;
    d = m_data;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'b00: begin m_sout = d[0];   d = (d >> 1) | (sis[i] ? 17'h1_0000 : 17'h0); end
        2'b01: begin m_sout = d[W-1]; d = (d << 1) | {16'h0, sis[i]}; end
        2'b10: begin m_sout = d[0];   d = W'($signed(d) >>> 1); end
        default: begin m_sout = d[0]; d = (d >> 1) | (d[0] ? 17'h1_0000 : 17'h0); end
      endcase
    end
    m_data = d;
  endtask

  // Called just after a negedge; returns at the negedge where Done is seen.
  task automatic run_seq(input logic [1:0] m, input int c, input bit rnd,
                         input bit si_c, input bit noise);
    int n;
    int busy_cnt;
    int done_at;
    bit si;
    bit sis[$];
    n = (c > 16) ? 16 : c;
    busy_cnt = 0;
    done_at = 0;
    Load = 1'b0; Start = 1'b1; Mode = m; Count = 5'(c);
    @(negedge Clk);
    Start = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
      if (Done) begin
        done_at = cyc;
        check("busy_with_done", 32'(Busy), 32'd0);
      end else begin
        if (Busy) begin
          busy_cnt++;
          si = rnd ? bit'($urandom_range(0, 1)) : si_c;
          Serial_In = si;
          sis.push_back(si);
          if (noise) begin
            Load  = 1'($urandom);
            D     = W'($urandom);
            Start = 1'($urandom);
            Mode  = 2'($urandom);
            Count = 5'($urandom);
          end
        end
        @(negedge Clk);
      end
    end
    Load = 1'b0; Start = 1'b0;
    model_shift(m, n, sis);
    last_busy = busy_cnt;
    check("seq_busy_cycles", 32'(busy_cnt), 32'(n));
    check("seq_done_cycle", 32'(done_at), 32'(n + 1));
    check("seq_data", 32'(Data_Out), 32'(m_data));
    check("seq_sout", 32'(Serial_Out), 32'(m_sout));
  endtask

  task automatic do_load(input logic [W-1:0] d);
    Load = 1'b1; Start = 1'b0; D = d;
    @(negedge Clk);
    Load = 1'b0;
    m_data = d;
    check("load_data", 32'(Data_Out), 32'(d));
  endtask

  task automatic end_check();
    @(negedge Clk);
    check("done_one_cycle", 32'(Done), 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1, 17'h1_0003, 2'b00, 5'd4,  1, 17'h1_F000, 0, 4};
    vecs[1] = '{1, 17'h1_0000, 2'b10, 5'd3,  0, 17'h1_E000, 0, 3};
    vecs[2] = '{1, 17'h0_0001, 2'b11, 5'd1,  0, 17'h1_0000, 1, 1};
    vecs[3] = '{0, 17'h0_0000, 2'b01, 5'd0,  0, 17'h1_0000, 1, 0};
    vecs[4] = '{1, 17'h0_00FF, 2'b01, 5'd8,  0, 17'h0_FF00, 0, 8};
    vecs[5] = '{1, 17'h1_2345, 2'b00, 5'd31, 0, 17'h0_0001, 0, 16};
    vecs[6] = '{1, 17'h1_8001, 2'b01, 5'd2,  1, 17'h0_0007, 1, 2};
    vecs[7] = '{1, 17'h1_F0F0, 2'b10, 5'd16, 0, 17'h1_FFFF, 1, 16};
    vecs[8] = '{1, 17'h0_0003, 2'b11, 5'd17, 0, 17'h0_0006, 0, 16};

    Reset = 1'b1; Load = 1'b0; D = '0; Start = 1'b0; Mode = 2'b00;
    Count = '0; Serial_In = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_data", 32'(Data_Out), 32'd0);
    check("rst_sout", 32'(Serial_Out), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    m_data = '0; m_sout = 1'b0;
    @(negedge Clk);

    foreach (vecs[i]) begin
      if (vecs[i].load) do_load(vecs[i].d);
      run_seq(vecs[i].mode, int'(vecs[i].cnt), 0, vecs[i].si, 0);
      check("vec_data", 32'(Data_Out), 32'(vecs[i].exp_d));
      check("vec_sout", 32'(Serial_Out), 32'(vecs[i].exp_so));
      check("vec_busy", 32'(last_busy), 32'(vecs[i].exp_busy));
      end_check();
    end

    // Reset part-way through an 8-shift sequence
    do_load(17'h1_ABCD);
    Start = 1'b1; Mode = 2'b00; Count = 5'd8;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("mid_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_data", 32'(Data_Out), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_sout", 32'(Serial_Out), 32'd0);
    m_data = '0; m_sout = 1'b0;
    run_seq(2'b00, 8, 1, 0, 0);
    end_check();

    // Load and Start together: load wins, no sequence starts
    Load = 1'b1; D = 17'h0_5A5A; Start = 1'b1; Mode = 2'b01; Count = 5'd5;
    @(negedge Clk);
    Load = 1'b0; Start = 1'b0;
    m_data = 17'h0_5A5A;
    check("ls_data", 32'(Data_Out), 32'h5A5A);
    check("ls_busy", 32'(Busy), 32'd0);
    check("ls_done", 32'(Done), 32'd0);
    @(negedge Clk);
    check("ls_busy2", 32'(Busy), 32'd0);
    check("ls_done2", 32'(Done), 32'd0);
    check("ls_data2", 32'(Data_Out), 32'h5A5A);

    // Noise on all control inputs during SHIFT, then back-to-back starts from DONE
    run_seq(2'b11, 5, 1, 0, 1);
    run_seq(2'b01, 2, 1, 0, 0);
    run_seq(2'b10, 3, 1, 0, 1);
    run_seq(2'b00, 0, 1, 0, 0);
    end_check();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
      run_seq(2'($urandom), int'($urandom_range(0, 31)), 1, 0, 1);
      if ($urandom_range(0, 3) != 0) end_check();
    end
    end_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
